// File: rtl/mmio_switch_port_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mmio_switch_port_pkg
// Purpose : Shared memory-command encodings, I/O address map and helpers for
//           the CPU, the top level and the switch peripheral.
// Contents: mem_cmd_e     - MNONE / MREAD / MWRITE bus command encodings
//           reg_sel_e     - which peripheral register an address selects
//           *_ADDR        - I/O address map (LED, switch data/edge/mask)
//           cnt_width()   - debounce counter width for a given cycle count
// Revision: 1.0 - initial release
// ============================================================================
package mmio_switch_port_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b11
  } mem_cmd_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DATA = 2'd1,
    SEL_EDGE = 2'd2,
    SEL_MASK = 2'd3
  } reg_sel_e;

  localparam logic [8:0] LED_ADDR     = 9'h100;
  localparam logic [8:0] SW_DATA_ADDR = 9'h140;
  localparam logic [8:0] SW_EDGE_ADDR = 9'h141;
  localparam logic [8:0] SW_MASK_ADDR = 9'h142;

  // One spare bit above clog2 so DEBOUNCE_CYCLES=1 still gets a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_switch_port_if.sv
`default_nettype none
// ============================================================================
// Module  : mmio_switch_port_if
// Purpose : CPU memory bus as seen by the switch peripheral.
// Signals : mem_cmd    (2)  CPU memory command (MNONE/MREAD/MWRITE)
//           mem_addr   (9)  CPU memory address
//           write_data (16) CPU store data
//           read_data  (16) peripheral read data, zero when read_en=0
//           read_en    (1)  peripheral owns the read bus this cycle
// Modports: master - CPU side; slave - peripheral side
// Revision: 1.0 - initial release
// ============================================================================
interface mmio_switch_port_if;

  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        read_en;

  modport master (
    output mem_cmd,
    output mem_addr,
    output write_data,
    input  read_data,
    input  read_en
  );

  modport slave (
    input  mem_cmd,
    input  mem_addr,
    input  write_data,
    output read_data,
    output read_en
  );

endinterface
`default_nettype wire

// File: rtl/mmio_switch_port_switch_debounce.sv
`default_nettype none
// ============================================================================
// Module  : switch_debounce
// Purpose : One switch bit: two-flop synchronizer, debounce counter and the
//           debounced stable level, plus a rise pulse marking the edge on
//           which stable goes 0->1.
// Ports   : clk      - system clock
//           reset    - asynchronous active-low reset
//           sw_in    - raw asynchronous switch level
//           stable   - debounced level
//           rise     - high during the cycle whose closing edge raises stable
// Revision: 1.0 - initial release
// ============================================================================
module switch_debounce
  import mmio_switch_port_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  sw_in,
  output logic stable,
  output logic rise
);

  localparam int unsigned c_cnt_w = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               stable_q, stable_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = sw_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise     = 1'b0;
    if (sync2_q == stable_q) begin
      // Any agreeing sample restarts the count, which is what rejects glitches.
      cnt_d = '0;
    end else if (cnt_q == c_cnt_last) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      rise     = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/mmio_switch_port.sv
`default_nettype none
// ============================================================================
// Module  : mmio_switch_port
// Purpose : Memory-mapped switch input peripheral. Debounces WIDTH switches,
//           latches rising edges in write-1-to-clear sticky bits and raises
//           irq for any edge bit enabled in the mask register.
// Ports   : clk    - system clock
//           reset  - asynchronous active-low reset
//           sw_in  - raw switch levels (WIDTH)
//           bus    - CPU memory bus (slave modport)
//           irq    - |(edge_reg & mask_reg)
// Map     : DATA_ADDR  read-only debounced value
//           EDGE_ADDR  sticky rising edges, write 1 to clear
//           MASK_ADDR  irq mask, read/write
// Revision: 1.0 - initial release
// ============================================================================
module mmio_switch_port
  import mmio_switch_port_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [8:0]  DATA_ADDR       = SW_DATA_ADDR,
  parameter logic [8:0]  EDGE_ADDR       = SW_EDGE_ADDR,
  parameter logic [8:0]  MASK_ADDR       = SW_MASK_ADDR
) (
  input  wire                  clk,
  input  wire                  reset,
  input  wire [WIDTH-1:0]      sw_in,
  mmio_switch_port_if.slave    bus,
  output logic                 irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] clr_bits;
  reg_sel_e         sel;
  logic             is_read;
  logic             is_write;
  logic [15:0]      read_data_w;
  logic             read_en_w;
  logic             unused_wdata_hi;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      switch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .sw_in  (sw_in[gi]),
        .stable (stable[gi]),
        .rise   (rise[gi])
      );
    end
  endgenerate

  always_comb begin
    sel = SEL_NONE;
    if (bus.mem_addr == DATA_ADDR) begin
      sel = SEL_DATA;
    end else if (bus.mem_addr == EDGE_ADDR) begin
      sel = SEL_EDGE;
    end else if (bus.mem_addr == MASK_ADDR) begin
      sel = SEL_MASK;
    end
  end

  assign is_read  = (bus.mem_cmd == MREAD);
  assign is_write = (bus.mem_cmd == MWRITE);
  assign wr_bits  = bus.write_data[WIDTH-1:0];

  // Bits above WIDTH never reach a register.
  assign unused_wdata_hi = ^bus.write_data;

  always_comb begin
    clr_bits = '0;
    mask_d   = mask_q;
    if (is_write && (sel == SEL_EDGE)) begin
      clr_bits = wr_bits;
    end
    if (is_write && (sel == SEL_MASK)) begin
      mask_d = wr_bits;
    end
    // OR-ing the rise after the clear makes a coincident new edge survive.
    edge_d = (edge_q & ~clr_bits) | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_q <= '0;
      mask_q <= '0;
    end else begin
      edge_q <= edge_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    read_en_w   = 1'b0;
    read_data_w = 16'h0000;
    if (is_read) begin
      case (sel)
        SEL_DATA: begin
          read_en_w   = 1'b1;
          read_data_w = 16'(stable);
        end
        SEL_EDGE: begin
          read_en_w   = 1'b1;
          read_data_w = 16'(edge_q);
        end
        SEL_MASK: begin
          read_en_w   = 1'b1;
          read_data_w = 16'(mask_q);
        end
        default: begin
          read_en_w   = 1'b0;
          read_data_w = 16'h0000;
        end
      endcase
    end
  end

  assign bus.read_en   = read_en_w;
  assign bus.read_data = read_data_w;
  assign irq           = |(edge_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_mmio_switch_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmio_switch_port
// Purpose : Self-checking bench for mmio_switch_port. Directed scenarios
//           followed by randomized traffic, all compared to a reference
//           model built from sliding windows of sampled switch inputs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mmio_switch_port;
  import mmio_switch_port_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] sw_in = '0;
  logic         irq;

  mmio_switch_port_if bus();

  mmio_switch_port #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw_in (sw_in),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit [W-1:0] m_stable;
  bit [W-1:0] m_edge;
  bit [W-1:0] m_mask;
  bit [W-1:0] hist[$];   // hist[0] = sample taken at the newest edge

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_stable = '0;
    m_edge   = '0;
    m_mask   = '0;
    hist.delete();
    for (int k = 0; k < D + 2; k++) hist.push_back('0);
  endtask

  function automatic logic [16:0] exp_bus();
    logic [15:0] d;
    logic        en;
    d  = 16'h0000;
    en = 1'b0;
    if (bus.mem_cmd == 2'b01) begin
      case (bus.mem_addr)
        9'h140: begin en = 1'b1; d = {8'h00, m_stable}; end
        9'h141: begin en = 1'b1; d = {8'h00, m_edge}; end
        9'h142: begin en = 1'b1; d = {8'h00, m_mask}; end
        default: begin en = 1'b0; d = 16'h0000; end
      endcase
    end
    return {en, d};
  endfunction

  task automatic check_bus(input string tag);
    logic [16:0] e;
    e = exp_bus();
    chk({tag, ".en"},   {31'd0, bus.read_en}, {31'd0, e[16]});
    chk({tag, ".data"}, {16'd0, bus.read_data}, {16'd0, e[15:0]});
    chk({tag, ".irq"},  {31'd0, irq}, {31'd0, |(m_edge & m_mask)});
  endtask

  task automatic set_bus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    bus.mem_cmd    = cmd;
    bus.mem_addr   = addr;
    bus.write_data = wd;
  endtask

  // Advance one clock. A switch level flips once the synchronized samples
  // seen over the last D edges all disagree with it.
  task automatic tick();
    bit [W-1:0] nstable;
    bit [W-1:0] rise;
    bit         flip;
    if (reset) begin
      hist.push_front(sw_in);
      hist.delete(hist.size() - 1);
      nstable = m_stable;
      for (int i = 0; i < W; i++) begin
        flip = 1'b1;
        for (int k = 2; k <= D + 1; k++) begin
          if (hist[k][i] == m_stable[i]) flip = 1'b0;
        end
        if (flip) nstable[i] = ~m_stable[i];
      end
      rise = nstable & ~m_stable;
      if (bus.mem_cmd == 2'b11 && bus.mem_addr == 9'h141)
        m_edge = m_edge & ~bus.write_data[W-1:0];
      if (bus.mem_cmd == 2'b11 && bus.mem_addr == 9'h142)
        m_mask = bus.write_data[W-1:0];
      m_edge   = m_edge | rise;
      m_stable = nstable;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic wr(input logic [8:0] addr, input logic [15:0] wd);
    set_bus(MWRITE, addr, wd);
    tick();
    set_bus(MNONE, 9'h000, 16'h0000);
  endtask

  task automatic rd(input string tag, input logic [8:0] addr, input logic en, input logic [15:0] exp);
    set_bus(MREAD, addr, 16'h0000);
    #1;
    check_bus(tag);
    chk({tag, ".dir_en"},   {31'd0, bus.read_en}, {31'd0, en});
    chk({tag, ".dir_data"}, {16'd0, bus.read_data}, {16'd0, exp});
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b0;
    #1;
    model_clear();
    check_bus("reset");
    ticks(hold);
    reset = 1'b1;
  endtask

  initial begin
    int r;
    set_bus(MNONE, 9'h000, 16'h0000);
    model_clear();

    // Reset and latency
    sw_in = 8'hFF;
    #2;
    check_bus("rst0");
    chk("rst0.irq0", {31'd0, irq}, 32'd0);
    ticks(3);
    reset = 1'b1;
    set_bus(MREAD, 9'h140, 16'h0000);
    for (int e = 1; e <= 6; e++) begin
      tick();
      check_bus("lat");
      chk("lat.dir", {16'd0, bus.read_data}, (e < 6) ? 32'h0 : 32'hFF);
    end
    rd("lat.edge", 9'h141, 1'b1, 16'h00FF);
    chk("lat.irq", {31'd0, irq}, 32'd0);

    // Glitch rejection
    wr(9'h141, 16'hFFFF);
    sw_in = 8'h00;
    ticks(8);
    sw_in[0] = 1'b1;
    ticks(3);
    sw_in[0] = 1'b0;
    ticks(8);
    rd("glitch.data", 9'h140, 1'b1, 16'h0000);
    rd("glitch.edge", 9'h141, 1'b1, 16'h0000);
    sw_in[0] = 1'b1;
    set_bus(MNONE, 9'h000, 16'h0000);
    ticks(6);
    rd("hold.edge", 9'h141, 1'b1, 16'h0001);

    // Write-1-to-clear
    sw_in[2] = 1'b1;
    set_bus(MNONE, 9'h000, 16'h0000);
    ticks(6);
    rd("w1c.pre", 9'h141, 1'b1, 16'h0005);
    wr(9'h141, 16'h0004);
    rd("w1c.clr", 9'h141, 1'b1, 16'h0001);
    wr(9'h141, 16'h0000);
    rd("w1c.zero", 9'h141, 1'b1, 16'h0001);

    // Set beats clear on the same edge
    sw_in[3] = 1'b1;
    set_bus(MNONE, 9'h000, 16'h0000);
    ticks(5);
    wr(9'h141, 16'h0008);
    rd("setwin", 9'h141, 1'b1, 16'h0009);

    // Mask and irq
    wr(9'h142, 16'h0002);
    sw_in[1] = 1'b1;
    ticks(6);
    check_bus("irq.set");
    chk("irq.on", {31'd0, irq}, 32'd1);
    rd("mask.rd", 9'h142, 1'b1, 16'h0002);
    wr(9'h141, 16'h0002);
    check_bus("irq.clr");
    chk("irq.off", {31'd0, irq}, 32'd0);

    // Decode
    rd("dec.led", 9'h100, 1'b0, 16'h0000);
    rd("dec.ram", 9'h040, 1'b0, 16'h0000);
    wr(9'h140, 16'hFFFF);
    rd("dec.ro", 9'h140, 1'b1, 16'h000F);
    set_bus(MNONE, 9'h141, 16'h0000);
    #1;
    check_bus("dec.none");
    chk("dec.none.en", {31'd0, bus.read_en}, 32'd0);

    // Reset mid-debounce with switches held through release
    set_bus(MNONE, 9'h000, 16'h0000);
    sw_in = 8'hF0;
    ticks(3);
    do_reset(2);
    set_bus(MREAD, 9'h140, 16'h0000);
    for (int e = 1; e <= 6; e++) begin
      tick();
      check_bus("rlat");
      chk("rlat.dir", {16'd0, bus.read_data}, (e < 6) ? 32'h0 : 32'hF0);
    end
    rd("rlat.edge", 9'h141, 1'b1, 16'h00F0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 11) == 0) sw_in[i] = ~sw_in[i];
      end
      r = $urandom_range(0, 3);
      bus.mem_cmd = (r == 0) ? MNONE : (r == 1) ? MREAD : (r == 2) ? MWRITE : 2'b10;
      r = $urandom_range(0, 5);
      bus.mem_addr = (r == 0) ? 9'h140 : (r == 1) ? 9'h141 : (r <= 3) ? 9'h142 :
                     (r == 4) ? 9'h100 : 9'($urandom_range(0, 511));
      bus.write_data = 16'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset(1);
      #1;
      check_bus("rnd.pre");
      tick();
      check_bus("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
